// File: rtl/btb_repl_policy_pkg.sv
// rtl/btb_repl_policy_pkg.sv - shared constants for the BTB replacement policy
package btb_repl_policy_pkg;

  // Replacement modes selectable at elaboration
  localparam int REPL_LFSR = 0;
  localparam int REPL_RR   = 1;
  localparam int REPL_NRU  = 2;

  // Default LFSR seed and Galois feedback mask
  localparam logic [15:0] REPL_LFSR_SEED = 16'h0001;
  localparam logic [15:0] REPL_LFSR_TAPS = 16'hB400;

endpackage

// File: rtl/btb_repl_prio_enc.sv
// rtl/btb_repl_prio_enc.sv - lowest-set-bit priority encoder
module btb_repl_prio_enc #(
  parameter int DEPTH  = 32,
  parameter int ADDR_W = 5
) (
  input  logic [DEPTH-1:0]  vec,
  output logic [ADDR_W-1:0] idx,
  output logic              any
);

  // Scan from the top down so the lowest set bit is the last one written
  always_comb begin
    idx = '0;
    any = 1'b0;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (vec[i]) begin
        idx = ADDR_W'(i);
        any = 1'b1;
      end
    end
  end

endmodule

// File: rtl/btb_repl_policy.sv
// rtl/btb_repl_policy.sv - victim selection for BTB-style associative tables
module btb_repl_policy
  import btb_repl_policy_pkg::*;
#(
  parameter int                DEPTH          = 32,
  parameter int                ADDR_W         = 5,
  parameter int                MODE           = REPL_LFSR,
  parameter int                PREFER_INVALID = 1,
  parameter int                LFSR_W         = 16,
  parameter logic [LFSR_W-1:0] INITIAL_VALUE  = LFSR_W'(REPL_LFSR_SEED),
  parameter logic [LFSR_W-1:0] TAP_VALUE      = LFSR_W'(REPL_LFSR_TAPS)
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              hit_i,
  input  logic [ADDR_W-1:0] hit_entry_i,
  input  logic              alloc_i,
  input  logic              flush_i,
  output logic [ADDR_W-1:0] alloc_entry_o,
  output logic              full_o
);

  // Reject unsupported configurations at elaboration
  if (MODE < REPL_LFSR || MODE > REPL_NRU) begin : g_bad_mode
    $error("btb_repl_policy: MODE must be 0, 1 or 2");
  end
  if (DEPTH != (1 << ADDR_W)) begin : g_bad_depth
    $error("btb_repl_policy: DEPTH must equal 2**ADDR_W");
  end
  if (LFSR_W < ADDR_W) begin : g_bad_lfsr_w
    $error("btb_repl_policy: LFSR_W must be >= ADDR_W");
  end
  if (INITIAL_VALUE == '0) begin : g_bad_seed
    $error("btb_repl_policy: INITIAL_VALUE must be non-zero");
  end

  logic [DEPTH-1:0]  valid_q;
  logic [DEPTH-1:0]  used_q;
  logic [LFSR_W-1:0] lfsr_q;
  logic [ADDR_W-1:0] ptr_q;

  logic [ADDR_W-1:0] inv_idx;
  logic              inv_any;
  logic [ADDR_W-1:0] nru_idx;
  logic              nru_any;
  logic [ADDR_W-1:0] policy_victim;
  logic [ADDR_W-1:0] victim;
  logic [LFSR_W-1:0] lfsr_next;
  logic [DEPTH-1:0]  used_set;
  logic [DEPTH-1:0]  used_or;
  logic [DEPTH-1:0]  used_next;

  btb_repl_prio_enc #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) u_inv_enc (
    .vec (~valid_q),
    .idx (inv_idx),
    .any (inv_any)
  );

  btb_repl_prio_enc #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) u_nru_enc (
    .vec (~used_q),
    .idx (nru_idx),
    .any (nru_any)
  );

  // Policy victim; an all-used NRU vector cannot persist, but falls back to 0
  always_comb begin
    policy_victim = lfsr_q[ADDR_W-1:0];
    case (MODE)
      REPL_RR:  policy_victim = ptr_q;
      REPL_NRU: policy_victim = nru_any ? nru_idx : '0;
      default:  policy_victim = lfsr_q[ADDR_W-1:0];
    endcase
  end

  // Fill empty slots first when enabled, otherwise defer to the policy
  always_comb begin
    victim = policy_victim;
    if (PREFER_INVALID != 0 && inv_any) begin
      victim = inv_idx;
    end
  end

  assign alloc_entry_o = victim;
  assign full_o        = ~inv_any;
  assign lfsr_next     = {1'b0, lfsr_q[LFSR_W-1:1]} ^ (lfsr_q[0] ? TAP_VALUE : '0);

  // NRU update: mark hit and allocated entries, restart the epoch on saturation
  always_comb begin
    used_set = '0;
    if (alloc_i) used_set[victim] = 1'b1;
    if (hit_i)   used_set[hit_entry_i] = 1'b1;
    used_or   = used_q | used_set;
    used_next = (&used_or) ? used_set : used_or;
  end

  // Validity tracking; flush wins over a same-cycle allocate
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      valid_q <= '0;
    end else if (flush_i) begin
      valid_q <= '0;
    end else if (alloc_i) begin
      valid_q[victim] <= 1'b1;
    end
  end

  // LFSR advances on every allocate and is deliberately kept across flush
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      lfsr_q <= INITIAL_VALUE;
    end else if (!flush_i && alloc_i && MODE == REPL_LFSR) begin
      lfsr_q <= lfsr_next;
    end
  end

  // Round-robin pointer wraps naturally because DEPTH is a power of two
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      ptr_q <= '0;
    end else if (flush_i) begin
      ptr_q <= '0;
    end else if (alloc_i && MODE == REPL_RR) begin
      ptr_q <= ptr_q + ADDR_W'(1);
    end
  end

  // Used bits for NRU, cleared by flush
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      used_q <= '0;
    end else if (flush_i) begin
      used_q <= '0;
    end else if (MODE == REPL_NRU && (alloc_i || hit_i)) begin
      used_q <= used_next;
    end
  end

endmodule

// File: tb/tb_btb_repl_policy.sv
// tb/tb_btb_repl_policy.sv - randomized and directed bench for btb_repl_policy
module tb_btb_repl_policy;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       hit = 1'b0;
  logic [4:0] hit_entry = '0;
  logic       alloc = 1'b0;
  logic       flush = 1'b0;

  logic [4:0] e0, e3;
  logic [1:0] e1, e2;
  logic       f0, f1, f2, f3;

  int n_cmp = 0;
  int n_err = 0;

  // Per-instance configuration and abstract reference state
  int dep[4];
  int md[4];
  int pi[4];
  bit mv[4][32];
  bit mu[4][32];
  int mptr[4];
  int mlfsr[4];

  always #5 clk = ~clk;

  btb_repl_policy #(.DEPTH(32), .ADDR_W(5), .MODE(0), .PREFER_INVALID(0)) d0 (
    .clk_i(clk), .rst_i(rst), .hit_i(hit), .hit_entry_i(hit_entry),
    .alloc_i(alloc), .flush_i(flush), .alloc_entry_o(e0), .full_o(f0));
  btb_repl_policy #(.DEPTH(4), .ADDR_W(2), .MODE(1), .PREFER_INVALID(1)) d1 (
    .clk_i(clk), .rst_i(rst), .hit_i(hit), .hit_entry_i(hit_entry[1:0]),
    .alloc_i(alloc), .flush_i(flush), .alloc_entry_o(e1), .full_o(f1));
  btb_repl_policy #(.DEPTH(4), .ADDR_W(2), .MODE(2), .PREFER_INVALID(1)) d2 (
    .clk_i(clk), .rst_i(rst), .hit_i(hit), .hit_entry_i(hit_entry[1:0]),
    .alloc_i(alloc), .flush_i(flush), .alloc_entry_o(e2), .full_o(f2));
  btb_repl_policy #(.DEPTH(32), .ADDR_W(5), .MODE(2), .PREFER_INVALID(1)) d3 (
    .clk_i(clk), .rst_i(rst), .hit_i(hit), .hit_entry_i(hit_entry),
    .alloc_i(alloc), .flush_i(flush), .alloc_entry_o(e3), .full_o(f3));

  function automatic void model_reset();
    for (int k = 0; k < 4; k++) begin
      for (int i = 0; i < 32; i++) begin
        mv[k][i] = 1'b0;
        mu[k][i] = 1'b0;
      end
      mptr[k]  = 0;
      mlfsr[k] = 1;
    end
  endfunction

  function automatic bit model_full(int k);
    for (int i = 0; i < dep[k]; i++) if (!mv[k][i]) return 1'b0;
    return 1'b1;
  endfunction

  function automatic int model_victim(int k);
    if (pi[k] != 0) begin
      for (int i = 0; i < dep[k]; i++) if (!mv[k][i]) return i;
    end
    if (md[k] == 0) return mlfsr[k] % dep[k];
    if (md[k] == 1) return mptr[k];
    for (int i = 0; i < dep[k]; i++) if (!mu[k][i]) return i;
    return 0;
  endfunction

  function automatic void model_step(bit a, bit h, int he, bit f);
    for (int k = 0; k < 4; k++) begin
      int  v;
      bit  all_used;
      bit  setnow[32];
      if (f) begin
        for (int i = 0; i < 32; i++) begin
          mv[k][i] = 1'b0;
          mu[k][i] = 1'b0;
        end
        mptr[k] = 0;
        continue;
      end
      v = model_victim(k);
      for (int i = 0; i < 32; i++) setnow[i] = 1'b0;
      if (a) begin
        mv[k][v] = 1'b1;
        if (md[k] == 0) mlfsr[k] = (mlfsr[k] % 2 == 1) ? ((mlfsr[k] / 2) ^ 32'hB400) : (mlfsr[k] / 2);
        if (md[k] == 1) mptr[k] = (mptr[k] + 1) % dep[k];
        setnow[v] = 1'b1;
      end
      if (h) setnow[he % dep[k]] = 1'b1;
      if (md[k] == 2 && (a || h)) begin
        all_used = 1'b1;
        for (int i = 0; i < dep[k]; i++) if (!(mu[k][i] || setnow[i])) all_used = 1'b0;
        for (int i = 0; i < dep[k]; i++) mu[k][i] = all_used ? setnow[i] : (mu[k][i] | setnow[i]);
      end
    end
  endfunction

  task automatic step(input bit a, input bit h, input int he, input bit f);
    alloc = a;
    hit = h;
    hit_entry = 5'(he);
    flush = f;
    @(posedge clk);
    model_step(a, h, he, f);
    #1;
    alloc = 1'b0;
    hit = 1'b0;
    flush = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    model_reset();
    #2;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    n_cmp++; if (e0 !== 5'd1) begin n_err++; $display("FAIL reset_e0 got %0d want 1", e0); end
    n_cmp++; if (e1 !== 2'd0) begin n_err++; $display("FAIL reset_e1 got %0d want 0", e1); end
    n_cmp++; if (e2 !== 2'd0) begin n_err++; $display("FAIL reset_e2 got %0d want 0", e2); end
    n_cmp++; if (e3 !== 5'd0) begin n_err++; $display("FAIL reset_e3 got %0d want 0", e3); end
    n_cmp++; if ({f0, f1, f2, f3} !== 4'b0) begin n_err++; $display("FAIL reset_full got %b want 0000", {f0, f1, f2, f3}); end
  endtask

  task automatic test_lfsr_sequence();
    logic [15:0] exp_l[7];
    logic [15:0] lv;
    exp_l = '{16'hB400, 16'h5A00, 16'h2D00, 16'h1680, 16'h0B40, 16'h05A0, 16'h02D0};
    do_reset();
    for (int i = 0; i < 7; i++) begin
      step(1'b1, 1'b0, 0, 1'b0);
      lv = d0.lfsr_q;
      n_cmp++; if (lv !== exp_l[i]) begin n_err++; $display("FAIL lfsr_%0d got %h want %h", i, lv, exp_l[i]); end
      n_cmp++; if (e0 !== ((i == 6) ? 5'd16 : 5'd0)) begin n_err++; $display("FAIL lfsr_entry_%0d got %0d want %0d", i, e0, (i == 6) ? 16 : 0); end
    end
  endtask

  task automatic test_invalid_first();
    logic [1:0] exp_e[6];
    exp_e = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0, 2'd1};
    do_reset();
    for (int i = 0; i < 6; i++) begin
      n_cmp++; if (e1 !== exp_e[i]) begin n_err++; $display("FAIL rr_entry_%0d got %0d want %0d", i, e1, exp_e[i]); end
      n_cmp++; if (f1 !== (i >= 4)) begin n_err++; $display("FAIL rr_full_%0d got %b want %b", i, f1, i >= 4); end
      step(1'b1, 1'b0, 0, 1'b0);
    end
  endtask

  task automatic test_nru();
    do_reset();
    for (int i = 0; i < 4; i++) step(1'b1, 1'b0, 0, 1'b0);
    n_cmp++; if (d2.used_q !== 4'b1000) begin n_err++; $display("FAIL nru_sat got %b want 1000", d2.used_q); end
    n_cmp++; if (e2 !== 2'd0) begin n_err++; $display("FAIL nru_sat_victim got %0d want 0", e2); end
    step(1'b0, 1'b1, 0, 1'b0);
    n_cmp++; if (d2.used_q !== 4'b1001) begin n_err++; $display("FAIL nru_hit got %b want 1001", d2.used_q); end
    n_cmp++; if (e2 !== 2'd1) begin n_err++; $display("FAIL nru_hit_victim got %0d want 1", e2); end
    step(1'b1, 1'b0, 0, 1'b0);
    n_cmp++; if (d2.used_q !== 4'b1011) begin n_err++; $display("FAIL nru_alloc got %b want 1011", d2.used_q); end
    n_cmp++; if (e2 !== 2'd2) begin n_err++; $display("FAIL nru_alloc_victim got %0d want 2", e2); end
  endtask

  task automatic test_hit_and_alloc();
    do_reset();
    for (int i = 0; i < 4; i++) step(1'b1, 1'b0, 0, 1'b0);
    step(1'b1, 1'b1, 1, 1'b0);
    n_cmp++; if (d2.used_q !== 4'b1011) begin n_err++; $display("FAIL both_1 got %b want 1011", d2.used_q); end
    n_cmp++; if (e2 !== 2'd2) begin n_err++; $display("FAIL both_1_victim got %0d want 2", e2); end
    step(1'b1, 1'b1, 2, 1'b0);
    n_cmp++; if (d2.used_q !== 4'b0100) begin n_err++; $display("FAIL both_2 got %b want 0100", d2.used_q); end
    n_cmp++; if (e2 !== 2'd0) begin n_err++; $display("FAIL both_2_victim got %0d want 0", e2); end
  endtask

  task automatic test_flush();
    do_reset();
    for (int i = 0; i < 5; i++) step(1'b1, 1'b0, 0, 1'b0);
    n_cmp++; if (f1 !== 1'b1) begin n_err++; $display("FAIL flush_pre_full got %b want 1", f1); end
    step(1'b1, 1'b0, 0, 1'b1);
    n_cmp++; if (f1 !== 1'b0) begin n_err++; $display("FAIL flush_full got %b want 0", f1); end
    n_cmp++; if (e1 !== 2'd0) begin n_err++; $display("FAIL flush_entry got %0d want 0", e1); end
    n_cmp++; if (d1.ptr_q !== 2'd0) begin n_err++; $display("FAIL flush_ptr got %0d want 0", d1.ptr_q); end
    n_cmp++; if (d1.valid_q !== 4'b0) begin n_err++; $display("FAIL flush_valid got %b want 0000", d1.valid_q); end
  endtask

  task automatic test_reset_mid_run();
    do_reset();
    for (int i = 0; i < 10; i++) step(1'b1, 1'b0, 0, 1'b0);
    #2;
    rst = 1'b1;
    model_reset();
    #1;
    n_cmp++; if (e0 !== 5'd1) begin n_err++; $display("FAIL midrst_e0 got %0d want 1", e0); end
    n_cmp++; if (e1 !== 2'd0 || f1 !== 1'b0) begin n_err++; $display("FAIL midrst_d1 got %0d/%b want 0/0", e1, f1); end
    @(negedge clk);
    rst = 1'b0;
    n_cmp++; if (d0.valid_q !== 32'b0) begin n_err++; $display("FAIL midrst_valid got %h want 0", d0.valid_q); end
    n_cmp++; if (d0.lfsr_q !== 16'h0001) begin n_err++; $display("FAIL midrst_lfsr got %h want 0001", d0.lfsr_q); end
  endtask

  task automatic test_random();
    int got_e;
    bit got_f;
    do_reset();
    for (int c = 0; c < 600; c++) begin
      step($urandom_range(0, 1) == 1, $urandom_range(0, 9) < 4,
           int'($urandom_range(0, 31)), $urandom_range(0, 39) == 0);
      for (int k = 0; k < 4; k++) begin
        case (k)
          0: begin got_e = int'(e0); got_f = f0; end
          1: begin got_e = int'(e1); got_f = f1; end
          2: begin got_e = int'(e2); got_f = f2; end
          default: begin got_e = int'(e3); got_f = f3; end
        endcase
        n_cmp++;
        if (got_e !== model_victim(k) || got_f !== model_full(k)) begin
          n_err++;
          $display("FAIL rand_c%0d_d%0d got entry %0d full %b want entry %0d full %b",
                   c, k, got_e, got_f, model_victim(k), model_full(k));
        end
      end
    end
  endtask

  initial begin
    dep = '{32, 4, 4, 32};
    md  = '{0, 1, 2, 2};
    pi  = '{0, 1, 1, 1};
    model_reset();
    test_reset();
    test_lfsr_sequence();
    test_invalid_first();
    test_nru();
    test_hit_and_alloc();
    test_flush();
    test_reset_mid_run();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
